// File: rtl/rx.sv
// UART receiver: 8 data bits, one parity bit, one stop bit, mid-bit sampling.
// Frame errors (bad parity or stop bit low) are flagged alongside the data strobe.
`timescale 1ns/1ps
module rx #(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE     = 19_200,
  parameter int unsigned PARITY        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       data_strobe,
  output logic       rx_error
);

  localparam int unsigned BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
  localparam int unsigned HALF_CLOCKS = BAUD_CLOCKS / 2;
  localparam int unsigned TW          = $clog2(BAUD_CLOCKS);
  localparam logic [TW-1:0] BAUD_LAST = TW'(BAUD_CLOCKS - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_CLOCKS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_din_prev;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [7:0]    r_dout;
  logic          r_strobe;
  logic          r_error;

  logic w_din_s;
  logic w_fall;
  logic w_half_hit;
  logic w_baud_hit;
  logic w_sample_data;
  logic w_sample_par;
  logic w_sample_stop;
  logic w_frame_err;

  assign w_din_s     = r_sync2;
  assign w_fall      = r_din_prev & ~w_din_s;
  assign w_half_hit  = (r_timer == HALF_LAST);
  assign w_baud_hit  = (r_timer == BAUD_LAST);
  // Odd mode wants the XOR over data+parity to be 1, even mode wants 0.
  assign w_frame_err = ((^{r_shift, r_par}) != 1'(PARITY)) || !w_din_s;

  assign dout        = r_dout;
  assign data_strobe = r_strobe;
  assign rx_error    = r_error;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_fall) w_next = START;
      START: if (w_half_hit) w_next = w_din_s ? IDLE : DATA;
      DATA:  if (w_baud_hit && (r_bit_idx == 3'd7)) w_next = PAR;
      PAR:   if (w_baud_hit) w_next = STOP;
      STOP:  if (w_baud_hit) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy          = (r_state != IDLE);
    w_sample_data = (r_state == DATA) && w_baud_hit;
    w_sample_par  = (r_state == PAR)  && w_baud_hit;
    w_sample_stop = (r_state == STOP) && w_baud_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_din_prev <= 1'b1;
      r_timer    <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_dout     <= '0;
      r_strobe   <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_sync1    <= din;
      r_sync2    <= r_sync1;
      r_din_prev <= r_sync2;
      r_strobe   <= w_sample_stop;

      case (r_state)
        IDLE:    r_timer <= '0;
        START:   r_timer <= w_half_hit ? '0 : r_timer + 1'b1;
        default: r_timer <= w_baud_hit ? '0 : r_timer + 1'b1;
      endcase

      if ((r_state == START) && w_half_hit) r_bit_idx <= '0;
      else if (w_sample_data)               r_bit_idx <= r_bit_idx + 1'b1;

      if (w_sample_data) r_shift <= {w_din_s, r_shift[7:1]};
      if (w_sample_par)  r_par   <= w_din_s;

      if (w_sample_stop) begin
        r_dout  <= r_shift;
        r_error <= w_frame_err;
      end
    end
  end

endmodule
